// File: rtl/riscv_axil_sram_pkg.sv
// Shared response codes, FSM state encodings and counter width for the AXI4-Lite SRAM responder.
package riscv_axil_sram_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  localparam int unsigned CntWidth = 4;

  typedef enum logic [1:0] {
    RIdle = 2'b00,
    RWait = 2'b01,
    RResp = 2'b10
  } rd_state_e;

  typedef enum logic [1:0] {
    WIdle = 2'b00,
    WWait = 2'b01,
    WResp = 2'b10
  } wr_state_e;

endpackage

// File: rtl/riscv_axil_lat_cnt.sv
// Loadable 4-bit latency down-counter; saturates at zero so WAIT states never see a wrap.
module riscv_axil_lat_cnt
  import riscv_axil_sram_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [CntWidth-1:0] load_val_i,
  input  logic                dec_i,
  output logic                zero_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/riscv_axil_sram.sv
// AXI4-Lite word-addressed memory responder with fixed, configurable read and write latency.
module riscv_axil_sram
  import riscv_axil_sram_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            MEM_DEPTH  = 4096,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned            RD_LATENCY = 1,
  parameter int unsigned            WR_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned IdxW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   MemBytes = (ADDR_WIDTH + 1)'(4 * MEM_DEPTH);
  localparam logic [CntWidth-1:0]   RdLoad   = CntWidth'(RD_LATENCY - 1);
  localparam logic [CntWidth-1:0]   WrLoad   = CntWidth'(WR_LATENCY - 1);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Low during reset so every ready is 0 then, and rises the cycle after release.
  logic ready_en_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
    end
  end

  // ---------------- Read channel ----------------
  rd_state_e             rd_state_q, rd_state_d;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  ar_hs, rd_load, rd_dec, rd_zero, rd_sample;
  logic [ADDR_WIDTH-1:0] rd_off;
  logic                  rd_in_range;
  logic [IdxW-1:0]       rd_idx;

  assign rd_off      = araddr_q - BASE_ADDR;
  assign rd_in_range = (araddr_q >= BASE_ADDR) && ({1'b0, rd_off} < MemBytes);
  assign rd_idx      = rd_off[IdxW+1:2];

  always_comb begin
    rd_state_d = rd_state_q;
    rd_load    = 1'b0;
    rd_dec     = 1'b0;
    rd_sample  = 1'b0;
    arready_o  = ready_en_q && (rd_state_q == RIdle);
    rvalid_o   = (rd_state_q == RResp);
    rdata_o    = rdata_q;
    rresp_o    = rresp_q;
    ar_hs      = arvalid_i && arready_o;
    case (rd_state_q)
      RIdle: begin
        if (ar_hs) begin
          rd_load    = 1'b1;
          rd_state_d = RWait;
        end
      end
      RWait: begin
        if (rd_zero) begin
          rd_sample  = 1'b1;
          rd_state_d = RResp;
        end else begin
          rd_dec = 1'b1;
        end
      end
      RResp: begin
        if (rready_i) begin
          rd_state_d = RIdle;
        end
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state_q <= RIdle;
      araddr_q   <= '0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
    end else begin
      rd_state_q <= rd_state_d;
      if (ar_hs) begin
        araddr_q <= araddr_i;
      end
      // A same-cycle commit to this word lands after this sample, so the old data is returned.
      if (rd_sample) begin
        rdata_q <= rd_in_range ? mem[rd_idx] : '0;
        rresp_q <= rd_in_range ? RespOkay : RespSlverr;
      end
    end
  end

  riscv_axil_lat_cnt u_rd_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (rd_load),
    .load_val_i (RdLoad),
    .dec_i      (rd_dec),
    .zero_o     (rd_zero)
  );

  // ---------------- Write channel ----------------
  wr_state_e             wr_state_q, wr_state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [StrbW-1:0]      wstrb_q;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [1:0]            bresp_q;
  logic                  aw_hs, w_hs, wr_load, wr_dec, wr_zero, wr_commit;
  logic [ADDR_WIDTH-1:0] wr_off;
  logic                  wr_in_range;
  logic [IdxW-1:0]       wr_idx;

  assign wr_off      = awaddr_q - BASE_ADDR;
  assign wr_in_range = (awaddr_q >= BASE_ADDR) && ({1'b0, wr_off} < MemBytes);
  assign wr_idx      = wr_off[IdxW+1:2];

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    wr_load    = 1'b0;
    wr_dec     = 1'b0;
    wr_commit  = 1'b0;
    awready_o  = ready_en_q && (wr_state_q == WIdle) && !aw_held_q;
    wready_o   = ready_en_q && (wr_state_q == WIdle) && !w_held_q;
    bvalid_o   = (wr_state_q == WResp);
    bresp_o    = bresp_q;
    aw_hs      = awvalid_i && awready_o;
    w_hs       = wvalid_i && wready_o;
    case (wr_state_q)
      WIdle: begin
        aw_held_d = aw_held_q || aw_hs;
        w_held_d  = w_held_q || w_hs;
        if (aw_held_d && w_held_d) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_load    = 1'b1;
          wr_state_d = WWait;
        end
      end
      WWait: begin
        if (wr_zero) begin
          wr_commit  = 1'b1;
          wr_state_d = WResp;
        end else begin
          wr_dec = 1'b1;
        end
      end
      WResp: begin
        if (bready_i) begin
          wr_state_d = WIdle;
        end
      end
      default: wr_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_q <= WIdle;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RespOkay;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      if (aw_hs) begin
        awaddr_q <= awaddr_i;
      end
      if (w_hs) begin
        wdata_q <= wdata_i;
        wstrb_q <= wstrb_i;
      end
      if (wr_commit) begin
        bresp_q <= wr_in_range ? RespOkay : RespSlverr;
      end
    end
  end

  // Gated by rst_n so a reset landing on the commit cycle leaves the array untouched.
  always_ff @(posedge clk) begin
    if (rst_n && wr_commit && wr_in_range) begin
      for (int b = 0; b < StrbW; b++) begin
        if (wstrb_q[b]) begin
          mem[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  riscv_axil_lat_cnt u_wr_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (wr_load),
    .load_val_i (WrLoad),
    .dec_i      (wr_dec),
    .zero_o     (wr_zero)
  );

endmodule

// File: tb/tb_riscv_axil_sram.sv
// Randomized bench for riscv_axil_sram against an array-based reference of the memory and timing.
module tb_riscv_axil_sram;

  localparam int unsigned  MEM_DEPTH  = 4096;
  localparam logic [31:0]  BASE       = 32'h8000_0000;
  localparam int unsigned  RD_LAT     = 3;
  localparam int unsigned  WR_LAT     = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model_mem [MEM_DEPTH];

  always #5 clk = ~clk;

  riscv_axil_sram #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (MEM_DEPTH),
    .BASE_ADDR  (BASE),
    .RD_LATENCY (RD_LAT),
    .WR_LATENCY (WR_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .araddr_i  (araddr),
    .arvalid_i (arvalid),
    .arready_o (arready),
    .rdata_o   (rdata),
    .rresp_o   (rresp),
    .rvalid_o  (rvalid),
    .rready_i  (rready),
    .awaddr_i  (awaddr),
    .awvalid_i (awvalid),
    .awready_o (awready),
    .wdata_i   (wdata),
    .wstrb_i   (wstrb),
    .wvalid_i  (wvalid),
    .wready_o  (wready),
    .bresp_o   (bresp),
    .bvalid_o  (bvalid),
    .bready_i  (bready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain byte-address arithmetic over an array.
  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * MEM_DEPTH));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    return in_rng(a) ? model_mem[widx(a)] : 32'h0;
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a);
    return in_rng(a) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_rng(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int n;
    araddr  = addr;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin
      tick();
      n++;
    end
    check_eq("ar_accept", 32'(arready), 32'd1);
    tick();
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 100) begin
      tick();
      lat++;
    end
    data = rdata;
    resp = rresp;
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq("r_hold_data", rdata, data);
      check_eq("r_hold_vld_ardy", {30'h0, rvalid, arready}, 32'b10);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int hold,
                          output logic [1:0] resp, output int lat);
    bit aw_done, w_done, aw_fire, w_fire;
    int t;
    aw_done = 1'b0;
    w_done  = 1'b0;
    t = 0;
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    while (!(aw_done && w_done) && t < 100) begin
      awvalid = !aw_done && (t >= aw_dly);
      wvalid  = !w_done && (t >= w_dly);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      tick();
      if (aw_fire) aw_done = 1'b1;
      if (w_fire) w_done = 1'b1;
      t++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check_eq("aw_w_accept", {30'h0, aw_done, w_done}, 32'b11);
    lat = 0;
    while (!bvalid && lat < 100) begin
      tick();
      lat++;
    end
    resp = bresp;
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq("b_hold", {29'h0, bvalid, bresp}, {29'h0, 1'b1, resp});
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  logic [31:0] d, d2, addr, wd;
  logic [1:0]  r, br;
  logic [3:0]  st;
  int          lat, wlat;

  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) begin
      model_mem[i] = $urandom;
    end
    model_mem[0] = 32'h0000_0013;
    model_mem[1] = 32'h1122_3344;
    model_mem[2] = 32'h0000_0001;
    model_mem[5] = 32'h0000_0055;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      dut.mem[i] = model_mem[i];
    end

    // Reset state
    tick();
    tick();
    check_eq("rst_ready", {29'h0, arready, awready, wready}, 32'h0);
    check_eq("rst_valid", {30'h0, rvalid, bvalid}, 32'h0);
    rst_n = 1'b1;
    check_eq("rel_ready_still_low", {29'h0, arready, awready, wready}, 32'h0);
    tick();
    check_eq("rel_ready_up", {29'h0, arready, awready, wready}, 32'h7);

    // 1: fetch with latency 3
    do_read(BASE, 0, d, r, lat);
    check_eq("t1_data", d, 32'h0000_0013);
    check_eq("t1_resp", 32'(r), 32'h0);
    check_eq("t1_lat", 32'(lat), 32'(RD_LAT));

    // 2: W two cycles ahead of AW, partial strobe
    do_write(BASE + 32'h4, 32'hAABB_CCDD, 4'b0101, 2, 0, 0, br, wlat);
    model_write(BASE + 32'h4, 32'hAABB_CCDD, 4'b0101);
    check_eq("t2_bresp", 32'(br), 32'h0);
    check_eq("t2_lat", 32'(wlat), 32'(WR_LAT));
    check_eq("t2_single_b", 32'(bvalid), 32'h0);
    do_read(BASE + 32'h4, 0, d, r, lat);
    check_eq("t2_data", d, 32'h11BB_33DD);

    // 3: out-of-range read and write
    do_read(32'h7FFF_FFFC, 0, d, r, lat);
    check_eq("t3_rresp", 32'(r), 32'h2);
    check_eq("t3_rdata", d, 32'h0);
    do_write(32'h8000_4000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, br, wlat);
    check_eq("t3_bresp", 32'(br), 32'h2);
    do_read(BASE, 0, d, r, lat);
    check_eq("t3_unchanged", d, model_mem[0]);

    // 4: rready held low for 5 cycles
    do_read(BASE + 32'h8, 5, d, r, lat);
    check_eq("t4_data", d, model_mem[2]);
    check_eq("t4_ar_after", 32'(arready), 32'h1);

    // 5: read sample and write commit in the same cycle on word 2
    fork
      begin
        do_read(BASE + 32'h8, 0, d, r, lat);
      end
      begin
        do_write(BASE + 32'h8, 32'h0000_0002, 4'hF, 1, 1, 0, br, wlat);
      end
    join
    check_eq("t5_old", d, 32'h0000_0001);
    model_write(BASE + 32'h8, 32'h0000_0002, 4'hF);
    do_read(BASE + 32'h8, 0, d, r, lat);
    check_eq("t5_new", d, 32'h0000_0002);

    // 6: reset while in W_WAIT drops the write
    awaddr  = BASE + 32'h14;
    wdata   = 32'hFFFF_FFFF;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    rst_n   = 1'b0;
    tick();
    check_eq("t6_ctl_zero", {25'h0, arready, rvalid, awready, wready, bvalid, rresp[1], bresp[1]},
             32'h0);
    check_eq("t6_rdata_zero", rdata, 32'h0);
    rst_n = 1'b1;
    check_eq("t6_ready_low", {29'h0, arready, awready, wready}, 32'h0);
    tick();
    check_eq("t6_ready_up", {29'h0, arready, awready, wready}, 32'h7);
    do_read(BASE + 32'h14, 0, d, r, lat);
    check_eq("t6_no_write", d, 32'h0000_0055);

    // Randomized traffic against the model
    for (int k = 0; k < 150; k++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 8) addr = BASE + 32'($urandom_range(0, 127));
      else if (sel == 8) addr = BASE + 32'h4000 + 32'($urandom_range(0, 255));
      else addr = BASE - 32'($urandom_range(1, 256));
      if ($urandom_range(0, 1) == 1) begin
        d2 = model_rdata(addr);
        do_read(addr, int'($urandom_range(0, 3)), d, r, lat);
        check_eq("rnd_rdata", d, d2);
        check_eq("rnd_rresp", 32'(r), 32'(model_resp(addr)));
        check_eq("rnd_rlat", 32'(lat), 32'(RD_LAT));
      end else begin
        wd = $urandom;
        st = 4'($urandom_range(0, 15));
        do_write(addr, wd, st, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), br, wlat);
        model_write(addr, wd, st);
        check_eq("rnd_bresp", 32'(br), 32'(model_resp(addr)));
        check_eq("rnd_wlat", 32'(wlat), 32'(WR_LAT));
      end
    end

    // Sweep the touched region to catch stray writes
    for (int i = 0; i < 64; i++) begin
      do_read(BASE + 32'(4 * i), 0, d, r, lat);
      check_eq("sweep", d, model_mem[i]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
